wcrc_encoder: RTL and testbench
===============================

// Module: wcrc_encoder
// PURPOSE
// - Producer side of the CRC-protected weight bus consumed by the s1neuron stage.
// - Accepts M raw n-bit weights over a valid/ready stream.
// - Computes a cl-bit CRC per weight bit-serially, packs each slot as {weight, crc}, and drives the flat Wcrc bus.
// - Keeps a golden shadow copy of the weights. When the neuron raises rfflag (CRC mismatch), re-encodes and redrives every slot.
// PARAMETERS
// - M         8       number of weights / Wcrc slots
// - n         16      weight width (fixed-point, intbits+fracbits)
// - cl        8       CRC width
// - POLY      8'h07   CRC-8 generator: MSB-first, init 0, no reflection, no final XOR
// PORTS
// - clk       in   1          single clock, rising edge
// - rst_n     in   1          asynchronous, active-low reset
// - w_data    in   n          raw weight
// - w_valid   in   1          w_data valid
// - w_ready   out  1          encoder can accept a weight
// - rfflag    in   1          refresh request from the neuron
// - Wcrc      out  M*(n+cl)   slot i = Wcrc[i*(n+cl) +: n+cl] = {w_i, crc_i}; slot 0 = first weight accepted
// - wcrc_valid out 1          all M slots hold consistent {weight, crc}
// - busy      out  1          encoding or refresh in progress
// BEHAVIOUR
// - Reset (async assert, sync deassert handled upstream):
//   - Wcrc = 0, shadow = 0, wcrc_valid = 0, busy = 0.
//   - w_ready = 1, slot index = 0, FSM = IDLE.
// - FSM states: IDLE, SHIFT, STORE, VALID, REFRESH.
// - IDLE (w_ready = 1): on w_valid & w_ready at edge k:
//   - shadow[idx] <= w_data; CRC register <= 0; bit counter <= n-1.
//   - Next state = SHIFT; w_ready drops the following cycle.
// - SHIFT: one weight bit per cycle, MSB first, for n cycles:
//   - fb = crc[cl-1] ^ bit.
//   - crc <= {crc[cl-2:0], 1'b0} ^ (fb ? POLY : 0).
// - STORE (1 cycle):
//   - Slot idx <= {shadow[idx], crc}.
//   - If idx == M-1: idx <= 0, next state = VALID. Otherwise idx++ and return to IDLE (or to REFRESH if refreshing).
// - Per-weight latency: handshake + n shift cycles + 1 store = n+2 cycles. A new weight is accepted at the earliest n+2 cycles after the previous one.
// - VALID:
//   - wcrc_valid = 1, busy = 0, w_ready = 0; Wcrc is held stable.
//   - Further w_valid is ignored until reset.
// - rfflag sampled high in VALID:
//   - wcrc_valid <= 0 and busy <= 1 on the next edge; enter REFRESH with idx = 0.
//   - Each slot is re-encoded from the shadow copy (n+1 cycles per slot), so the total is M*(n+1) cycles.
//   - Then return to VALID. Slots are overwritten in place as each completes.
// - rfflag outside VALID is ignored; it is not queued. A rfflag held high across VALID re-triggers every time VALID is entered.
// - busy = 1 in SHIFT/STORE/REFRESH; busy = 0 in IDLE/VALID.
// - The CRC is computed over the weight bits only; the resulting Wcrc slots pass s1neuron's CRC check (rfflag low).
// - Reset asserted mid-SHIFT/REFRESH: immediate return to reset values; the partial CRC is discarded.
// STRUCTURE
// - Shared package (ft_pkg):
//   - localparams CRC_W = 8 and CRC_POLY = 8'h07.
//   - SLOT_W = n+cl.
//   - FSM state typedef/encoding, shared with the neuron-side checker.
// - One sub-module: crc8_serial (clk, rst_n, clr, en, bit_in -> crc[cl-1:0]). Reused by a future serial checker.
// - Top level owns the FSM, slot index, bit counter, shadow array and Wcrc register.
// TESTING
// 1. Load 8 x 16'h0400, w_valid held high:
//    - Wcrc = {8{24'h040054}}.
//    - wcrc_valid rises 8*18 cycles after the first handshake; w_ready is high for one cycle per weight.
// 2. Load 8 x 16'h0000:
//    - every slot = 24'h000000; wcrc_valid = 1.
// 3. Stall between weights (w_valid low 5 cycles):
//    - no slot is written with stale data; slot order matches acceptance order.
// 4. In VALID, force one Wcrc bit via the bench (neuron flags an error), pulse rfflag one cycle:
//    - wcrc_valid = 0 on the next edge; busy = 1.
//    - After 8*17 cycles, Wcrc equals the scenario-1 value again and wcrc_valid = 1.
// 5. Pulse rfflag during the initial load, idx = 3:
//    - ignored; the load completes normally with the same timing as scenario 1.
// 6. Assert rst_n = 0 asynchronously mid-SHIFT of slot 5:
//    - all outputs return to reset values within the same cycle; the reload from idx 0 succeeds.
// - Every scenario: a reference-model scoreboard recomputes CRC-8/0x07 per slot.
// - Also feed Wcrc into the s1neuron stage and check rfflag = 0 whenever wcrc_valid = 1.

Source files
------------

// File: rtl/ft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ft_pkg : CRC-8 constants, slot geometry and FSM encoding shared by the     |
// |          weight encoder and the neuron-side checker.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ft_pkg;

   localparam int           CRC_W    = 8;
   localparam logic [7:0]   CRC_POLY = 8'h07;
   localparam int           WEIGHT_W = 16;
   localparam int           SLOT_W   = WEIGHT_W + CRC_W;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_STORE   = 3'd2;
   localparam logic [2:0] ST_VALID   = 3'd3;
   localparam logic [2:0] ST_REFRESH = 3'd4;

endpackage
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc8_serial : bit-serial MSB-first CRC, init 0, no reflection/final XOR.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module crc8_serial #(
   parameter int            cl   = 8,
   parameter logic [cl-1:0] POLY = 8'h07
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          bit_in,
   output logic [cl-1:0] crc
);

   logic w_fb;

   assign w_fb = crc[cl-1] ^ bit_in;

   // clr wins over en so a new message can start on the same edge a store happens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[cl-2:0], 1'b0} ^ (w_fb ? POLY : '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/wcrc_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wcrc_encoder : packs M weights as {weight, crc} slots on the Wcrc bus and  |
// |                re-encodes all slots from a shadow copy on rfflag.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wcrc_encoder
   import ft_pkg::*;
#(
   parameter int            M    = 8,
   parameter int            n    = WEIGHT_W,
   parameter int            cl   = CRC_W,
   parameter logic [cl-1:0] POLY = CRC_POLY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [n-1:0]          w_data,
   input  logic                  w_valid,
   output logic                  w_ready,
   input  logic                  rfflag,
   output logic [M*(n+cl)-1:0]   Wcrc,
   output logic                  wcrc_valid,
   output logic                  busy
);

   localparam int SW    = n + cl;
   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
   localparam int BIT_W = (n > 1) ? $clog2(n) : 1;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(M - 1);
   localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(n - 1);

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [BIT_W-1:0]  r_bitcnt;
   logic              r_refresh;
   logic [n-1:0]      r_shadow [M];
   logic [SW-1:0]     r_slot   [M];

   logic              w_accept;
   logic              w_shift_en;
   logic              w_clr;
   logic              w_bit;
   logic [cl-1:0]     w_crc;

   assign w_ready    = (r_state == ST_IDLE);
   assign wcrc_valid = (r_state == ST_VALID);
   assign busy       = (r_state == ST_SHIFT) || (r_state == ST_STORE) || (r_state == ST_REFRESH);

   assign w_accept   = w_valid && w_ready;
   assign w_shift_en = (r_state == ST_SHIFT) || (r_state == ST_REFRESH);
   // Clearing on every store is harmless: the slot captures the CRC before the edge
   assign w_clr      = w_accept || (r_state == ST_STORE) || ((r_state == ST_VALID) && rfflag);
   assign w_bit      = r_shadow[r_idx][r_bitcnt];

   crc8_serial #(
      .cl   (cl),
      .POLY (POLY)
   ) u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_clr),
      .en     (w_shift_en),
      .bit_in (w_bit),
      .crc    (w_crc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_bitcnt  <= '0;
         r_refresh <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_bitcnt <= c_last_bit;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT, ST_REFRESH: begin
               if (r_bitcnt == '0) begin
                  r_state <= ST_STORE;
               end else begin
                  r_bitcnt <= r_bitcnt - 1'b1;
               end
            end
            ST_STORE: begin
               r_bitcnt <= c_last_bit;
               if (r_idx == c_last_idx) begin
                  r_idx     <= '0;
                  r_refresh <= 1'b0;
                  r_state   <= ST_VALID;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= r_refresh ? ST_REFRESH : ST_IDLE;
               end
            end
            ST_VALID: begin
               if (rfflag) begin
                  r_refresh <= 1'b1;
                  r_idx     <= '0;
                  r_bitcnt  <= c_last_bit;
                  r_state   <= ST_REFRESH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < M; i++) begin
            r_shadow[i] <= '0;
            r_slot[i]   <= '0;
         end
      end else begin
         if (w_accept) begin
            r_shadow[r_idx] <= w_data;
         end
         if (r_state == ST_STORE) begin
            r_slot[r_idx] <= {r_shadow[r_idx], w_crc};
         end
      end
   end

   for (genvar g = 0; g < M; g++) begin : g_pack
      assign Wcrc[g*SW +: SW] = r_slot[g];
   end

endmodule
`default_nettype wire

// File: tb/tb_wcrc_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wcrc_encoder : self-checking bench for wcrc_encoder (table vectors,     |
// |                   directed timing/refresh/reset sequences, random loads).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_wcrc_encoder;
   import ft_pkg::*;

   localparam int M  = 8;
   localparam int N  = 16;
   localparam int CL = 8;
   localparam int SW = N + CL;
   localparam int BW = M * SW;

   typedef struct {
      logic [N-1:0]  w;
      logic [SW-1:0] slot;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  w_data = '0;
   logic          w_valid = 1'b0;
   logic          rfflag = 1'b0;
   logic          w_ready;
   logic [BW-1:0] Wcrc;
   logic          wcrc_valid;
   logic          busy;

   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            ready_cnt = 0;
   logic          count_en = 1'b0;
   logic [N-1:0]  sent [$];

   wcrc_encoder #(.M(M), .n(N), .cl(CL), .POLY(8'h07)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .w_data     (w_data),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .rfflag     (rfflag),
      .Wcrc       (Wcrc),
      .wcrc_valid (wcrc_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CRC as the remainder of polynomial long division of w*x^8 by x^8+x^2+x+1
   function automatic logic [CL-1:0] ref_crc(input logic [N-1:0] w);
      logic [N+CL-1:0] r;
      r = {w, {CL{1'b0}}};
      for (int b = N + CL - 1; b >= CL; b--) begin
         if (r[b]) r[b -: CL+1] = r[b -: CL+1] ^ {1'b1, CRC_POLY};
      end
      return r[CL-1:0];
   endfunction

   function automatic logic [BW-1:0] exp_bus();
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < sent.size() && i < M; i++) r[i*SW +: SW] = {sent[i], ref_crc(sent[i])};
      return r;
   endfunction

   // Neuron-side view: any slot whose stored CRC disagrees raises rfflag
   function automatic logic neuron_err(input logic [BW-1:0] bus);
      logic e;
      e = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (ref_crc(bus[i*SW+CL +: N]) != bus[i*SW +: CL]) e = 1'b1;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (count_en && w_ready) ready_cnt++;
      if (rst_n && wcrc_valid) begin
         n_cmp++;
         if (neuron_err(Wcrc)) begin
            n_bad++;
            $display("FAIL neuron_rfflag: got 1 expected 0 (bus %h)", Wcrc);
         end
      end
   end

   task automatic do_reset();
      w_valid = 1'b0;
      rfflag  = 1'b0;
      rst_n   = 1'b0;
      sent.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // gap > 0 holds w_valid low for that many cycles while the encoder is already idle
   task automatic send(input logic [N-1:0] d, input int gap, output int hs);
      int b;
      b = 0;
      if (gap == 0) begin
         w_valid = 1'b1;
         w_data  = d;
      end else begin
         w_valid = 1'b0;
         w_data  = N'($urandom);
      end
      while (!w_ready && b < 200) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (!w_ready) check_int("handshake_timeout", 0, 1);
      if (gap > 0) begin
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         w_valid = 1'b1;
         w_data  = d;
      end
      @(posedge clk);
      #1;
      hs = cyc;
      sent.push_back(d);
   endtask

   task automatic wait_valid(output int v);
      int b;
      b = 0;
      while (!wcrc_valid && b < 2000) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (!wcrc_valid) check_int("valid_timeout", 0, 1);
      v = cyc;
   endtask

   initial begin
      vec_t          tbl [M];
      int            hs, h0, v, r;
      logic [BW-1:0] hold;

      tbl[0] = '{16'h0400, 24'h040054};
      tbl[1] = '{16'h0000, 24'h000000};
      tbl[2] = '{16'h0001, 24'h000107};
      tbl[3] = '{16'h0100, 24'h010015};
      tbl[4] = '{16'h8000, 24'h8000B6};
      tbl[5] = '{16'h00FF, 24'h00FFF3};
      tbl[6] = '{16'h0400, 24'h040054};
      tbl[7] = '{16'h0001, 24'h000107};

      // Reset state
      #2;
      check("rst_wcrc", Wcrc, '0);
      check_int("rst_valid", int'(wcrc_valid), 0);
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_ready", int'(w_ready), 1);
      do_reset();

      // Load 8 x 0x0400 with w_valid held high: timing and ready pulses
      ready_cnt = 0;
      count_en  = 1'b1;
      h0 = 0;
      for (int i = 0; i < M; i++) begin
         send(16'h0400, 0, hs);
         if (i == 0) h0 = hs;
      end
      wait_valid(v);
      count_en = 1'b0;
      check_int("s1_valid_latency", v - h0, M * (N + 2) - 1);
      check_int("s1_ready_cycles", ready_cnt, M);
      check("s1_bus", Wcrc, {M{24'h040054}});
      check("s1_model", Wcrc, exp_bus());
      check_int("s1_busy", int'(busy), 0);

      // Inputs in VALID are ignored
      hold = Wcrc;
      for (int k = 0; k < 10; k++) begin
         w_valid = 1'b1;
         w_data  = N'($urandom);
         @(posedge clk);
         #1;
      end
      w_valid = 1'b0;
      check("valid_hold_bus", Wcrc, hold);
      check_int("valid_hold_ready", int'(w_ready), 0);

      // Neuron sees a flipped bit and pulses rfflag for one cycle
      if (neuron_err(Wcrc ^ (BW'(1) << 37))) begin
         rfflag = 1'b1;
         @(posedge clk);
         #1;
         rfflag = 1'b0;
         r = cyc;
         check_int("rf_valid_drop", int'(wcrc_valid), 0);
         check_int("rf_busy", int'(busy), 1);
         repeat (70) @(posedge clk);
         #1;
         check_int("rf_mid_busy", int'(busy), 1);
         check("rf_mid_bus", Wcrc, {M{24'h040054}});
         wait_valid(v);
         check_int("rf_latency", v - r, M * (N + 1));
         check("rf_bus", Wcrc, {M{24'h040054}});
      end

      // rfflag held high re-triggers as soon as VALID is re-entered
      rfflag = 1'b1;
      @(posedge clk);
      #1;
      wait_valid(v);
      @(posedge clk);
      #1;
      check_int("rf_held_retrigger", int'(busy), 1);
      rfflag = 1'b0;
      wait_valid(v);
      check("rf_held_bus", Wcrc, exp_bus());

      // rfflag during the initial load is ignored
      do_reset();
      h0 = 0;
      for (int i = 0; i < M; i++) begin
         send(16'h0400, 0, hs);
         if (i == 0) h0 = hs;
         if (i == 3) begin
            rfflag = 1'b1;
            @(posedge clk);
            #1;
            rfflag = 1'b0;
         end
      end
      wait_valid(v);
      check_int("s5_latency", v - h0, M * (N + 2) - 1);
      check("s5_bus", Wcrc, {M{24'h040054}});

      // All-zero weights
      do_reset();
      for (int i = 0; i < M; i++) send(16'h0000, 0, hs);
      wait_valid(v);
      check("s2_bus", Wcrc, '0);
      check_int("s2_valid", int'(wcrc_valid), 1);

      // Table vectors with mixed stalls
      do_reset();
      for (int i = 0; i < M; i++) send(tbl[i].w, i % 3, hs);
      wait_valid(v);
      for (int i = 0; i < M; i++) check($sformatf("tbl_slot%0d", i), BW'(Wcrc[i*SW +: SW]), BW'(tbl[i].slot));

      // Async reset in the middle of slot 5's shift
      do_reset();
      for (int i = 0; i < 6; i++) send(N'($urandom_range(1, 16'hFFFF)), 0, hs);
      w_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_int("s6_busy_before", int'(busy), 1);
      #3 rst_n = 1'b0;
      #1;
      check("s6_rst_bus", Wcrc, '0);
      check_int("s6_rst_valid", int'(wcrc_valid), 0);
      check_int("s6_rst_busy", int'(busy), 0);
      check_int("s6_rst_ready", int'(w_ready), 1);
      sent.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < M; i++) send(N'($urandom), 0, hs);
      wait_valid(v);
      check("s6_reload", Wcrc, exp_bus());

      // Random weights with random stalls (including a 5-cycle stall)
      for (int it = 0; it < 4; it++) begin
         do_reset();
         for (int i = 0; i < M; i++) send(N'($urandom), (i == 2) ? 5 : int'($urandom_range(0, 5)), hs);
         w_valid = 1'b0;
         wait_valid(v);
         check($sformatf("rand%0d_bus", it), Wcrc, exp_bus());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
